hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//   Central hazard/stall sequencer for the 5-stage MIPS pipeline. Drives stage stall/flush
//   enables, EX forwarding selects and the ID-stage branch/jr compare forwards (ForwardC/ForwardD).
//   Owns a memory-wait FSM with timeout watchdog and a saturating stall-cycle counter.
//   Sits beside the pipeline registers; sees register indices and control bits from D/E/M/W.
// PARAMETERS
//   REG_W      5      register index width
//   TIMEOUT    16     max consecutive MEM_WAIT cycles before FAULT (>=1)
//   CNT_W      32     width of StallCnt
// PORTS
//   clk          in   1      pipeline clock, all state on rising edge
//   rst          in   1      asynchronous, active-low reset
//   RsD, RtD     in   REG_W  ID source registers
//   BranchD      in   1      ID holds beq/bne
//   JrD          in   1      ID holds jr
//   JumpD        in   1      ID holds j/jal/jr
//   PCSrcD       in   1      ID branch taken
//   RsE, RtE     in   REG_W  EX source registers
//   WriteRegE    in   REG_W  EX destination; RegWriteE, MemtoRegE in 1 each
//   WriteRegM    in   REG_W  MEM destination; RegWriteM, MemtoRegM in 1 each
//   WriteRegW    in   REG_W  WB destination; RegWriteW in 1
//   MemReqM      in   1      MEM stage issuing data-memory access
//   MemReadyM    in   1      data memory completes access this cycle
//   StallF/StallD/StallE/StallM  out 1  hold the respective pipeline register
//   FlushD, FlushE, FlushW       out 1  clear the respective pipeline register (bubble)
//   ForwardAE, ForwardBE         out 2  00 regfile, 01 WB result, 10 ALUOutM
//   ForwardC, ForwardD           out 1  ID compare/jr operand from ALUOutM
//   MemTimeout   out  1      sticky fault flag
//   StallCnt     out  CNT_W  cycles with StallD=1, saturating
// BEHAVIOUR
//   Match(x,y): x!=0 && x==y. Register 0 never matches.
//   Forwarding (pure comb): ForwardAE=10 if RegWriteM&Match(WriteRegM,RsE); else 01 if
//     RegWriteW&Match(WriteRegW,RsE); else 00. ForwardBE same on RtE; M wins over W.
//     ForwardC = RegWriteM & !MemtoRegM & Match(WriteRegM,RsD); ForwardD same on RtD.
//   lwstall = MemtoRegE & RegWriteE & (Match(WriteRegE,RsD)|Match(WriteRegE,RtD)).
//   brstall = (BranchD|JrD) & ( RegWriteE & (Match(WriteRegE,RsD)|BranchD&Match(WriteRegE,RtD))
//            | MemtoRegM & (Match(WriteRegM,RsD)|BranchD&Match(WriteRegM,RtD)) ).
//     Load feeding branch thus stalls 2 cycles, ALU op feeding branch 1 cycle.
//   FSM states RUN, MEM_WAIT, FAULT (registered; reset -> RUN):
//     RUN: freeze = MemReqM & !MemReadyM. If freeze -> MEM_WAIT, WaitCnt<=1.
//     MEM_WAIT: freeze=1 unless MemReadyM. MemReadyM -> RUN, WaitCnt<=0 (that cycle unfrozen).
//       else WaitCnt==TIMEOUT -> FAULT, MemTimeout<=1; else WaitCnt++.
//     FAULT: freeze=1 forever; only rst exits. MemTimeout stays 1.
//   Outputs, priority freeze > hazard stall > redirect:
//     freeze: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
//     else lwstall|brstall: StallF=StallD=1, FlushE=1, FlushD=0, others 0.
//     else FlushD = PCSrcD|JumpD; all stalls 0.
//   Forward selects are valid in every state (comb from inputs).
//   StallCnt += 1 each cycle StallD=1 (freeze or hazard); holds at all-ones.
//   Reset (rst=0, async): state RUN, WaitCnt 0, MemTimeout 0, StallCnt 0. Stall/flush
//     outputs follow RUN equations from current inputs.
//   Reset mid-MEM_WAIT/FAULT: immediate return to RUN, no freeze next cycle unless re-triggered.
// STRUCTURE
//   hazard_pkg: state encoding (RUN=2'd0, MEM_WAIT=2'd1, FAULT=2'd2), forward codes
//     FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
//   Sub-module fwd_unit: combinational ForwardAE/BE/C/D; FSM, stall logic, counters in top.
// TESTING
//   1 lw $2 (E), add uses $2 (D) -> 1 cycle StallF=StallD=FlushE=1, next cycle ForwardAE=01.
//   2 add $3 (E), beq $3,$4 (D) -> 1 stall; next cycle ForwardC=1, no stall.
//   3 lw $5 then beq $0,$5 -> 2 consecutive stall cycles; StallCnt +2; ForwardD never 1.
//   4 Writes to $0 in E/M/W with RsE=RsD=0 -> all forwards 00, no stalls.
//   5 MemReqM=1, MemReadyM low 3 cycles then high -> freeze 3 cycles, RUN on ready cycle.
//   6 MemReadyM held low, TIMEOUT=4 -> FAULT after 5 freeze cycles, MemTimeout=1; rst=0 clears.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and types for the hazard/stall sequencer.
//   ST_*    : memory-wait FSM state encoding
//   FWD_*   : EX-stage forward mux select codes
//   fwd_sel_t : bundle of all forward selects produced by fwd_unit
package hazard_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // WB-stage result
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALUOutM

  typedef struct packed {
    logic [1:0] ae;  // EX operand A select
    logic [1:0] be;  // EX operand B select
    logic       c;   // ID compare/jr operand Rs from ALUOutM
    logic       d;   // ID compare operand Rt from ALUOutM
  } fwd_sel_t;

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: purely combinational forwarding selects.
//   in : RsD/RtD (ID sources), RsE/RtE (EX sources), WriteRegM/RegWriteM/MemtoRegM,
//        WriteRegW/RegWriteW
//   out: fwd (ForwardAE/BE 2-bit codes, ForwardC/D 1-bit)
// The MEM stage is younger than WB, so an M match takes precedence over a W match.
// ForwardC/D only take ALUOutM; a load in M has no data yet, hence !MemtoRegM.
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteW,
  output fwd_sel_t         fwd
);

  // Register 0 is hard-wired, so it never matches a producer.
  function automatic logic reg_match(input logic [REG_W-1:0] x, input logic [REG_W-1:0] y);
    return (x != '0) && (x == y);
  endfunction

  function automatic logic [1:0] ex_sel(input logic [REG_W-1:0] src);
    if (RegWriteM && reg_match(WriteRegM, src))      return FWD_MEM;
    else if (RegWriteW && reg_match(WriteRegW, src)) return FWD_WB;
    else                                             return FWD_RF;
  endfunction

  always_comb begin
    fwd    = '0;
    fwd.ae = ex_sel(RsE);
    fwd.be = ex_sel(RtE);
    fwd.c  = RegWriteM && !MemtoRegM && reg_match(WriteRegM, RsD);
    fwd.d  = RegWriteM && !MemtoRegM && reg_match(WriteRegM, RtD);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard/stall sequencer for the 5-stage pipeline.
//   in : clk, rst (async active-low), ID/EX/MEM/WB register indices and control bits,
//        MemReqM/MemReadyM data-memory handshake
//   out: StallF/D/E/M, FlushD/E/W, ForwardAE/BE/C/D, MemTimeout (sticky), StallCnt
// Priority of pipeline control: memory freeze > load-use/branch stall > redirect flush.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic             BranchD,
  input  logic             JrD,
  input  logic             JumpD,
  input  logic             PCSrcD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardC,
  output logic             ForwardD,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCnt
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  fwd_sel_t fwd;

  fwd_unit #(.REG_W(REG_W)) u_fwd (
    .RsD       (RsD),
    .RtD       (RtD),
    .RsE       (RsE),
    .RtE       (RtE),
    .WriteRegM (WriteRegM),
    .RegWriteM (RegWriteM),
    .MemtoRegM (MemtoRegM),
    .WriteRegW (WriteRegW),
    .RegWriteW (RegWriteW),
    .fwd       (fwd)
  );

  assign ForwardAE = fwd.ae;
  assign ForwardBE = fwd.be;
  assign ForwardC  = fwd.c;
  assign ForwardD  = fwd.d;

  function automatic logic reg_match(input logic [REG_W-1:0] x, input logic [REG_W-1:0] y);
    return (x != '0) && (x == y);
  endfunction

  // ---------------- hazard detection ----------------
  logic lwstall, brstall;

  always_comb begin
    lwstall = MemtoRegE && RegWriteE &&
              (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD));
    // jr only reads Rs; beq/bne read both. A load in M still cannot feed the
    // ID comparator (only ALUOutM is forwarded), giving the second stall cycle.
    brstall = (BranchD || JrD) &&
              ((RegWriteE && (reg_match(WriteRegE, RsD) ||
                              (BranchD && reg_match(WriteRegE, RtD)))) ||
               (MemtoRegM && (reg_match(WriteRegM, RsD) ||
                              (BranchD && reg_match(WriteRegM, RtD)))));
  end

  // ---------------- memory-wait FSM ----------------
  logic [1:0]      state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic            freeze;

  always_comb begin
    freeze        = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      ST_RUN: begin
        if (MemReqM && !MemReadyM) begin
          freeze     = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (MemReadyM) begin
          // Completion cycle is not frozen: the access retires this edge.
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_q == WC_W'(TIMEOUT)) begin
            state_d       = ST_FAULT;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end
        end
      end
      ST_FAULT: freeze = 1'b1;  // only reset leaves FAULT
      default:  state_d = ST_RUN;
    endcase
  end

  // ---------------- stall / flush outputs ----------------
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (freeze) begin
      // Whole front of the pipe holds; WB gets a bubble so nothing retires twice.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (lwstall || brstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      FlushD = PCSrcD || JumpD;
    end
  end

  // Saturating count of StallD cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallD && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign MemTimeout = mem_timeout_q;
  assign StallCnt   = stall_cnt_q;

endmodule
